// File: rtl/ir_key_pkg.sv
// Shared definitions for the IR key entry buffer.
//   ASCII_ZERO / ASCII_SPACE : characters written to / padded into the LCD line
//   key_class_t              : what a received key code means to the buffer
//   classify()               : maps a raw code onto key_class_t, given the
//                              codes used for backspace, clear and enter
package ir_key_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    KC_DIGIT,
    KC_BKSP,
    KC_CLEAR,
    KC_ENTER,
    KC_OTHER
  } key_class_t;

  // Codes are zero-extended to 32 bits so one function serves any CODE_W.
  // Digits are checked first so a control-key code can never shadow 0..9.
  function automatic key_class_t classify(input logic [31:0] code,
                                          input logic [31:0] key_bksp,
                                          input logic [31:0] key_clear,
                                          input logic [31:0] key_enter);
    if (code < 32'd10)           return KC_DIGIT;
    else if (code == key_bksp)   return KC_BKSP;
    else if (code == key_clear)  return KC_CLEAR;
    else if (code == key_enter)  return KC_ENTER;
    else                         return KC_OTHER;
  endfunction

endpackage

// File: rtl/ir_repeat_filter.sv
// Stage 1 of the key entry pipeline: registers the incoming strobe and drops
// IR auto-repeats of a held key.
//   clk, rst_n       : clock, asynchronous active-low reset
//   code_valid, code : one-cycle strobe and key code from the IR receiver
//   acc_valid        : one-cycle pulse, a strobe was accepted (one cycle later)
//   acc_code         : last accepted code; holds between strobes
module ir_repeat_filter #(
  parameter int CODE_W     = 8,
  parameter int REPEAT_GAP = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              acc_valid,
  output logic [CODE_W-1:0] acc_code
);

  localparam int               GAP_W   = $clog2(REPEAT_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(REPEAT_GAP);

  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              acc_valid_q, acc_valid_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  logic              is_repeat;

  // gap_q holds the number of clock edges since the last strobe (the strobe's
  // own edge counts as 1), saturating at REPEAT_GAP. Every strobe restarts it,
  // dropped or not, so a held key keeps itself suppressed. Resetting it to
  // the saturated value lets the first strobe after reset through whatever
  // its code is.
  always_comb begin
    is_repeat   = (code == acc_code_q) && (gap_q < GAP_MAX);
    gap_d       = gap_q;
    acc_valid_d = 1'b0;
    acc_code_d  = acc_code_q;
    if (code_valid) begin
      gap_d = GAP_W'(1);
      if (!is_repeat) begin
        acc_valid_d = 1'b1;
        acc_code_d  = code;
      end
    end else if (gap_q < GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q       <= GAP_MAX;
      acc_valid_q <= 1'b0;
      acc_code_q  <= '0;
    end else begin
      gap_q       <= gap_d;
      acc_valid_q <= acc_valid_d;
      acc_code_q  <= acc_code_d;
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_code  = acc_code_q;

endmodule

// File: rtl/ir_key_entry_buffer.sv
// Collects IR digit keys as ASCII into a one-line LCD buffer.
//   clk, rst_n       : clock, asynchronous active-low reset
//   code_valid, code : key strobe and code from the IR receiver
//   char_addr        : LCD read address; char_data is registered (1 cycle)
//   count, full      : characters held, buffer full flag
//   last_code        : last accepted raw code, for the 7-segment display
//   update           : pulse, buffer contents changed
//   overflow         : pulse, a digit was dropped because the buffer was full
//   entry_done       : pulse on enter; entry_len holds the count at that enter
module ir_key_entry_buffer
  import ir_key_pkg::*;
#(
  parameter int                CODE_W     = 8,
  parameter int                DEPTH      = 16,
  parameter int                REPEAT_GAP = 5_000_000,
  parameter logic [CODE_W-1:0] KEY_BKSP   = CODE_W'(8'h0C),
  parameter logic [CODE_W-1:0] KEY_CLEAR  = CODE_W'(8'h0F),
  parameter logic [CODE_W-1:0] KEY_ENTER  = CODE_W'(8'h0D)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       code_valid,
  input  logic [CODE_W-1:0]          code,
  input  logic [$clog2(DEPTH)-1:0]   char_addr,
  output logic [7:0]                 char_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [CODE_W-1:0]          last_code,
  output logic                       update,
  output logic                       overflow,
  output logic                       entry_done,
  output logic [$clog2(DEPTH):0]     entry_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              acc_valid;
  logic [CODE_W-1:0] acc_code;
  key_class_t        acc_class;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] entry_len_q, entry_len_d;
  logic          update_q, update_d;
  logic          overflow_q, overflow_d;
  logic          entry_done_q, entry_done_d;
  logic [7:0]    char_data_q, char_data_d;
  logic          is_full;

  ir_repeat_filter #(
    .CODE_W     (CODE_W),
    .REPEAT_GAP (REPEAT_GAP)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .acc_valid  (acc_valid),
    .acc_code   (acc_code)
  );

  assign is_full = (count_q == CW'(DEPTH));

  // Stage 2: act on the accepted key. Digits append at index count_q, which
  // is always in range because appends are refused once the buffer is full.
  always_comb begin
    acc_class    = classify(32'(acc_code), 32'(KEY_BKSP), 32'(KEY_CLEAR), 32'(KEY_ENTER));
    count_d      = count_q;
    entry_len_d  = entry_len_q;
    update_d     = 1'b0;
    overflow_d   = 1'b0;
    entry_done_d = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = ASCII_ZERO + {4'd0, acc_code[3:0]};
    if (acc_valid) begin
      case (acc_class)
        KC_DIGIT: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            count_d  = count_q + CW'(1);
            update_d = 1'b1;
          end
        end
        KC_BKSP: begin
          if (count_q != '0) begin
            count_d  = count_q - CW'(1);
            update_d = 1'b1;
          end
        end
        KC_CLEAR: begin
          if (count_q != '0) begin
            count_d  = '0;
            update_d = 1'b1;
          end
        end
        KC_ENTER: begin
          entry_len_d  = count_q;
          entry_done_d = 1'b1;
          count_d      = '0;
          update_d     = (count_q != '0);
        end
        default: begin
        end
      endcase
    end
  end

  // Read port sees the pre-write mem and count; slots at or past count read
  // as blanks so stale characters never reach the LCD.
  always_comb begin
    char_data_d = ({1'b0, char_addr} < count_q) ? mem_q[char_addr] : ASCII_SPACE;
  end

  // Character storage has no reset; slots beyond count are never shown.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      entry_len_q  <= '0;
      update_q     <= 1'b0;
      overflow_q   <= 1'b0;
      entry_done_q <= 1'b0;
      char_data_q  <= ASCII_SPACE;
    end else begin
      count_q      <= count_d;
      entry_len_q  <= entry_len_d;
      update_q     <= update_d;
      overflow_q   <= overflow_d;
      entry_done_q <= entry_done_d;
      char_data_q  <= char_data_d;
    end
  end

  assign char_data  = char_data_q;
  assign count      = count_q;
  assign full       = is_full;
  assign last_code  = acc_code;
  assign update     = update_q;
  assign overflow   = overflow_q;
  assign entry_done = entry_done_q;
  assign entry_len  = entry_len_q;

endmodule

// File: tb/tb_ir_key_entry_buffer.sv
// Self-checking bench for ir_key_entry_buffer: directed scenarios followed by
// random key traffic, all checked against a queue-based line-buffer model.
module tb_ir_key_entry_buffer;

  localparam int         CODE_W     = 8;
  localparam int         DEPTH      = 16;
  localparam int         REPEAT_GAP = 20;
  localparam logic [7:0] K_BKSP     = 8'h0C;
  localparam logic [7:0] K_CLEAR    = 8'h0F;
  localparam logic [7:0] K_ENTER    = 8'h0D;

  logic              clk;
  logic              rst_n;
  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic [3:0]        char_addr;
  logic [7:0]        char_data;
  logic [4:0]        count;
  logic              full;
  logic [CODE_W-1:0] last_code;
  logic              update;
  logic              overflow;
  logic              entry_done;
  logic [4:0]        entry_len;

  ir_key_entry_buffer #(
    .CODE_W     (CODE_W),
    .DEPTH      (DEPTH),
    .REPEAT_GAP (REPEAT_GAP),
    .KEY_BKSP   (K_BKSP),
    .KEY_CLEAR  (K_CLEAR),
    .KEY_ENTER  (K_ENTER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code       (code),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .count      (count),
    .full       (full),
    .last_code  (last_code),
    .update     (update),
    .overflow   (overflow),
    .entry_done (entry_done),
    .entry_len  (entry_len)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Free-running edge counter used by the model to measure strobe spacing
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model state: the LCD line as a queue of characters
  logic [7:0] lineBuf [$];
  logic [7:0] lastAccCode;
  bit         seenAny;
  int         lastStrobeCyc;
  logic [7:0] expLastCode;
  logic [4:0] expEntryLen;
  bit         expUpd, expOvf, expDone;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    lineBuf.delete();
    lastAccCode   = 8'h00;
    seenAny       = 1'b0;
    lastStrobeCyc = 0;
    expLastCode   = 8'h00;
    expEntryLen   = 5'd0;
  endtask

  // Apply the key rules to one strobe seen at edge index c
  task automatic modelStrobe(input logic [7:0] k, input int c);
    bit accepted;
    accepted = !seenAny || (k != lastAccCode) || ((c - lastStrobeCyc) >= REPEAT_GAP);
    lastStrobeCyc = c;
    expUpd  = 1'b0;
    expOvf  = 1'b0;
    expDone = 1'b0;
    if (accepted) begin
      seenAny     = 1'b1;
      lastAccCode = k;
      expLastCode = k;
      if (k < 8'd10) begin
        if (lineBuf.size() < DEPTH) begin
          lineBuf.push_back(8'h30 + k);
          expUpd = 1'b1;
        end else begin
          expOvf = 1'b1;
        end
      end else if (k == K_BKSP) begin
        if (lineBuf.size() > 0) begin
          void'(lineBuf.pop_back());
          expUpd = 1'b1;
        end
      end else if (k == K_CLEAR) begin
        if (lineBuf.size() > 0) begin
          lineBuf.delete();
          expUpd = 1'b1;
        end
      end else if (k == K_ENTER) begin
        expEntryLen = 5'(lineBuf.size());
        expDone     = 1'b1;
        expUpd      = (lineBuf.size() > 0);
        lineBuf.delete();
      end
    end
  endtask

  // Wait idle cycles, strobe one key, then check the N+1 and N+2 views and
  // that the pulses last exactly one cycle
  task automatic applyStimulus(input logic [7:0] k, input int idle);
    repeat (idle) @(posedge clk);
    @(posedge clk);
    #1 code = k; code_valid = 1'b1;
    @(posedge clk);
    #1 code_valid = 1'b0; code = 8'($urandom);
    modelStrobe(k, cyc);
    checkOutput("last_code_n1", last_code, expLastCode);
    checkOutput("update_n1", update, 0);
    checkOutput("overflow_n1", overflow, 0);
    checkOutput("entry_done_n1", entry_done, 0);
    @(posedge clk);
    #1;
    checkOutput("update_n2", update, expUpd);
    checkOutput("overflow_n2", overflow, expOvf);
    checkOutput("entry_done_n2", entry_done, expDone);
    checkOutput("count", count, lineBuf.size());
    checkOutput("full", full, lineBuf.size() == DEPTH);
    checkOutput("entry_len", entry_len, expEntryLen);
    @(posedge clk);
    #1;
    checkOutput("update_n3", update, 0);
    checkOutput("overflow_n3", overflow, 0);
    checkOutput("entry_done_n3", entry_done, 0);
  endtask

  task automatic readCheck(input int a);
    logic [7:0] expChar;
    @(posedge clk);
    #1 char_addr = 4'(a);
    @(posedge clk);
    #1;
    expChar = (a < lineBuf.size()) ? lineBuf[a] : 8'h20;
    checkOutput($sformatf("char_data[%0d]", a), char_data, expChar);
  endtask

  // Directed scenarios, then random traffic
  initial begin
    logic [7:0] k;
    logic [7:0] prevKey;
    int sel;

    rst_n = 1'b0; code_valid = 1'b0; code = '0; char_addr = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_count", count, 0);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_last_code", last_code, 0);
    checkOutput("reset_entry_len", entry_len, 0);
    checkOutput("reset_update", update, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_entry_done", entry_done, 0);
    checkOutput("reset_char_data", char_data, 8'h20);
    for (int a = 0; a < DEPTH; a++) readCheck(a);

    $display("[TB] digits 1,2,3");
    applyStimulus(8'h01, 27);
    applyStimulus(8'h02, 27);
    applyStimulus(8'h03, 27);
    for (int a = 0; a < 4; a++) readCheck(a);

    $display("[TB] repeat filter on key 7");
    applyStimulus(8'h07, 25);
    applyStimulus(8'h07, 2);
    applyStimulus(8'h07, 12);
    applyStimulus(8'h07, 22);
    checkOutput("repeat_count", count, 5);

    $display("[TB] fill and overflow");
    applyStimulus(K_CLEAR, 25);
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'(i % 10), 25);
    applyStimulus(8'h05, 25);
    for (int a = 0; a < DEPTH; a++) readCheck(a);

    $display("[TB] backspace and enter");
    applyStimulus(K_CLEAR, 25);
    applyStimulus(8'h01, 25);
    applyStimulus(8'h02, 25);
    applyStimulus(8'h03, 25);
    applyStimulus(K_BKSP, 25);
    readCheck(2);
    applyStimulus(K_ENTER, 25);
    checkOutput("entry_len_two", entry_len, 2);
    applyStimulus(K_BKSP, 25);
    applyStimulus(K_ENTER, 25);
    applyStimulus(8'h40, 25);

    $display("[TB] random traffic");
    prevKey = 8'h00;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 3) k = prevKey;
      else if (sel < 6) k = 8'($urandom_range(0, 9));
      else if (sel == 6) k = K_BKSP;
      else if (sel == 7) k = K_CLEAR;
      else if (sel == 8) k = K_ENTER;
      else k = 8'($urandom_range(16, 255));
      prevKey = k;
      applyStimulus(k, $urandom_range(0, 25));
      if (n % 20 == 19) begin
        for (int a = 0; a < DEPTH; a++) readCheck(a);
      end
    end

    $display("[TB] reset with a strobe in flight");
    applyStimulus(K_CLEAR, 25);
    applyStimulus(8'h04, 25);
    @(posedge clk);
    #1 code = 8'h06; code_valid = 1'b1;
    @(posedge clk);
    #1 code_valid = 1'b0; rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_update", update, 0);
      checkOutput("rst_entry_done", entry_done, 0);
      checkOutput("rst_count", count, 0);
      @(posedge clk);
      #1;
    end
    checkOutput("rst_last_code", last_code, 0);
    applyStimulus(8'h06, 0);
    readCheck(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
